// File: rtl/reg_write_arbiter.sv
// Shared-register write arbiter: round-robin grant among NREQ requesters.
// Each grant lasts one cycle and is followed by one cool-down cycle.
module reg_write_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic [NREQ-1:0]    Req,
  input  logic [NREQ*DW-1:0] Wr_Data,
  output logic [NREQ-1:0]    Gnt,
  output logic [DW-1:0]      Q,
  output logic               Q_valid,
  output logic               Busy,
  output logic [7:0]         Wr_Count
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     last, last_nxt;
  logic [IW-1:0]     win, win_nxt;
  logic [IW-1:0]     rr_idx;
  logic              rr_hit;
  logic [NREQ-1:0]   gnt_nxt;
  logic [DW-1:0]     q_nxt;
  logic              q_valid_nxt;
  logic              busy_nxt;
  logic [7:0]        cnt_nxt;
  logic [DW-1:0]     slice [NREQ];
  int unsigned       cand;

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      slice[i] = Wr_Data[i*int'(DW) +: DW];
    end
  end

  // Round-robin search starting one past the most recent winner
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = last;
    cand   = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = (32'(last) + k) % NREQ;
      if (!rr_hit && Req[IW'(cand)]) begin
        rr_hit = 1'b1;
        rr_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = '0;
    q_nxt       = Q;
    q_valid_nxt = Q_valid;
    cnt_nxt     = Wr_Count;
    last_nxt    = last;
    win_nxt     = win;
    case (state)
      IDLE: begin
        if (rr_hit) begin
          gnt_nxt   = NREQ'(1) << rr_idx;
          win_nxt   = rr_idx;
          state_nxt = GRANT;
        end
      end
      // Grant is committed: write happens even if the winner dropped Req
      GRANT: begin
        q_nxt       = slice[win];
        q_valid_nxt = 1'b1;
        cnt_nxt     = Wr_Count + 8'd1;
        last_nxt    = win;
        state_nxt   = COOL;
      end
      COOL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= IDLE;
      Gnt      <= '0;
      Q        <= '0;
      Q_valid  <= 1'b0;
      Busy     <= 1'b0;
      Wr_Count <= '0;
      last     <= IW'(NREQ - 1);
      win      <= '0;
    end else begin
      state    <= state_nxt;
      Gnt      <= gnt_nxt;
      Q        <= q_nxt;
      Q_valid  <= q_valid_nxt;
      Busy     <= busy_nxt;
      Wr_Count <= cnt_nxt;
      last     <= last_nxt;
      win      <= win_nxt;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter (NREQ=4, DW=4).
module tb_reg_write_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [3:0]  Req;
  logic [15:0] Wr_Data;
  logic [3:0]  Gnt;
  logic [3:0]  Q;
  logic        Q_valid;
  logic        Busy;
  logic [7:0]  Wr_Count;

  int checks = 0;
  int errors = 0;
  logic [3:0] prev_gnt = '0;

  reg_write_arbiter #(.NREQ(4), .DW(4)) dut (
    .Clk(Clk), .Rst(Rst), .Req(Req), .Wr_Data(Wr_Data),
    .Gnt(Gnt), .Q(Q), .Q_valid(Q_valid), .Busy(Busy), .Wr_Count(Wr_Count)
  );

  always #5 Clk = ~Clk;

  // Advance one cycle, then check the always-true grant properties
  task automatic tick();
    @(posedge Clk);
    #1;
    checks++;
    if (!$onehot0(Gnt)) begin
      errors++; $display("FAIL onehot0 Gnt=%b at %0t", Gnt, $time);
    end
    checks++;
    if (Gnt != 4'b0 && !Busy) begin
      errors++; $display("FAIL gnt_without_busy Gnt=%b Busy=%b at %0t", Gnt, Busy, $time);
    end
    if (prev_gnt != 4'b0) begin
      checks++;
      if (Gnt !== 4'b0) begin
        errors++; $display("FAIL gnt_in_cool Gnt=%b expected 0000 at %0t", Gnt, $time);
      end
    end
    prev_gnt = Gnt;
  endtask

  task automatic do_reset();
    Rst = 1'b1; Req = '0; Wr_Data = '0;
    tick(); tick();
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({Gnt, Q, Q_valid, Busy, Wr_Count} !== 18'b0) begin
      errors++;
      $display("FAIL reset Gnt=%b Q=%h Qv=%b Busy=%b Cnt=%0d expected all zero",
               Gnt, Q, Q_valid, Busy, Wr_Count);
    end
  endtask

  task automatic test_single();
    do_reset();
    Req = 4'b0100; Wr_Data = 16'h0A00;
    tick();
    checks++;
    if (Gnt !== 4'b0100 || Busy !== 1'b1 || Q !== 4'h0) begin
      errors++; $display("FAIL single_grant Gnt=%b Busy=%b Q=%h expected 0100 1 0", Gnt, Busy, Q);
    end
    Req = 4'b0000;
    tick();
    checks++;
    if (Q !== 4'hA || Q_valid !== 1'b1 || Wr_Count !== 8'd1 || Gnt !== 4'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL single_write Q=%h Qv=%b Cnt=%0d Gnt=%b Busy=%b expected A 1 1 0000 1",
               Q, Q_valid, Wr_Count, Gnt, Busy);
    end
    tick();
    checks++;
    if (Busy !== 1'b0) begin
      errors++; $display("FAIL single_idle Busy=%b expected 0", Busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] gseq [5];
    logic [3:0] qseq [5];
    gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    qseq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    do_reset();
    Req = 4'b1111; Wr_Data = 16'h4321;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (Gnt !== gseq[i]) begin
        errors++; $display("FAIL rr_gnt[%0d] Gnt=%b expected %b", i, Gnt, gseq[i]);
      end
      tick();
      checks++;
      if (Q !== qseq[i] || Wr_Count !== 8'(i + 1)) begin
        errors++; $display("FAIL rr_q[%0d] Q=%h Cnt=%0d expected %h %0d", i, Q, Wr_Count, qseq[i], i + 1);
      end
      tick();
      checks++;
      if (Gnt !== 4'b0 || Busy !== 1'b0) begin
        errors++; $display("FAIL rr_idle[%0d] Gnt=%b Busy=%b expected 0000 0", i, Gnt, Busy);
      end
    end
    Req = 4'b0000;
    tick();
  endtask

  task automatic test_dropped();
    do_reset();
    Req = 4'b0010; Wr_Data = 16'h0050;
    tick();
    checks++;
    if (Gnt !== 4'b0010) begin
      errors++; $display("FAIL drop_gnt Gnt=%b expected 0010", Gnt);
    end
    Req = 4'b0000;
    tick();
    checks++;
    if (Q !== 4'h5 || Q_valid !== 1'b1 || Wr_Count !== 8'd1) begin
      errors++; $display("FAIL drop_write Q=%h Qv=%b Cnt=%0d expected 5 1 1", Q, Q_valid, Wr_Count);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (Gnt !== 4'b0 || Wr_Count !== 8'd1) begin
        errors++; $display("FAIL drop_no_regrant[%0d] Gnt=%b Cnt=%0d expected 0000 1", i, Gnt, Wr_Count);
      end
    end
  endtask

  task automatic test_pending_kept();
    do_reset();
    Req = 4'b1010; Wr_Data = 16'h9080;
    tick();
    checks++;
    if (Gnt !== 4'b0010) begin
      errors++; $display("FAIL pend_first Gnt=%b expected 0010", Gnt);
    end
    Req = 4'b1000;
    tick(); tick(); tick();
    checks++;
    if (Gnt !== 4'b1000) begin
      errors++; $display("FAIL pend_second Gnt=%b expected 1000", Gnt);
    end
    Req = 4'b0000;
    tick();
    checks++;
    if (Q !== 4'h9 || Wr_Count !== 8'd2) begin
      errors++; $display("FAIL pend_write Q=%h Cnt=%0d expected 9 2", Q, Wr_Count);
    end
    tick();
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    Req = 4'b1000; Wr_Data = 16'hF000;
    tick();
    checks++;
    if (Gnt !== 4'b1000) begin
      errors++; $display("FAIL midrst_gnt Gnt=%b expected 1000", Gnt);
    end
    Rst = 1'b1;
    tick();
    checks++;
    if ({Gnt, Q, Q_valid, Busy, Wr_Count} !== 18'b0) begin
      errors++;
      $display("FAIL midrst_clear Gnt=%b Q=%h Qv=%b Busy=%b Cnt=%0d expected all zero",
               Gnt, Q, Q_valid, Busy, Wr_Count);
    end
    Rst = 1'b0;
    tick();
    checks++;
    if (Gnt !== 4'b1000) begin
      errors++; $display("FAIL post_rst_grant Gnt=%b expected 1000", Gnt);
    end
    Req = 4'b0000;
    tick(); tick();
  endtask

  task automatic test_wrap();
    do_reset();
    Req = 4'b0001;
    for (int n = 1; n <= 256; n++) begin
      Wr_Data = 16'(n & 15);
      tick(); tick();
      if (n == 1 || n == 255 || n == 256) begin
        checks++;
        if (Wr_Count !== 8'(n) || Q !== 4'(n & 15)) begin
          errors++; $display("FAIL wrap[%0d] Cnt=%0d Q=%h expected %0d %h", n, Wr_Count, Q, n % 256, n & 15);
        end
      end
      tick();
    end
    Req = 4'b0000;
    tick();
  endtask

  initial begin
    Rst = 1'b1; Req = '0; Wr_Data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_dropped();
    test_pending_kept();
    test_reset_mid_grant();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
